// File: rtl/uart_frame_sched.sv
// Two-channel round-robin frame scheduler in front of a byte-wide UART driver.
// Each granted packet goes out as HDR, ID, LEN, payload, CSUM (ID+LEN+payload mod 256).
module uart_frame_sched #(
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ch0_req,
  input  logic [7:0] ch0_len,
  input  logic [7:0] ch0_data,
  output logic       ch0_rd,
  output logic       ch0_done,
  input  logic       ch1_req,
  input  logic [7:0] ch1_len,
  input  logic [7:0] ch1_data,
  output logic       ch1_rd,
  output logic       ch1_done,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_en,
  input  logic       uart_tx_done,
  output logic       busy,
  output logic       active_ch
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_FETCH = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    B_HDR  = 3'd0,
    B_ID   = 3'd1,
    B_LEN  = 3'd2,
    B_PAY  = 3'd3,
    B_CSUM = 3'd4
  } byte_t;

  state_t     r_state;
  state_t     w_state;
  byte_t      r_last;
  byte_t      w_last;
  logic       r_last_grant;
  logic       w_last_grant;
  logic       r_active;
  logic       w_active;
  logic [7:0] r_rem;
  logic [7:0] w_rem;
  logic [7:0] r_csum;
  logic [7:0] w_csum;
  logic [7:0] r_tx_data;
  logic [7:0] w_tx_data;
  logic       r_tx_en;
  logic       r_rd0;
  logic       r_rd1;
  logic       r_done0;
  logic       r_done1;
  logic       r_busy;
  logic       w_grant_ch;
  logic       w_frame_end;
  logic       w_can_grant;
  logic [7:0] w_pay;
  logic [7:0] w_id;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] val);
    return acc + val;
  endfunction

  assign w_pay = r_active ? ch1_data : ch0_data;
  assign w_id  = {7'd0, r_active};
  // A source still sees its own req high during its done pulse, so no grant is made in that cycle.
  assign w_can_grant = (ch0_req | ch1_req) & ~(r_done0 | r_done1);

  // Next-state, datapath and byte sequencing.
  always_comb begin
    w_state      = r_state;
    w_last       = r_last;
    w_last_grant = r_last_grant;
    w_active     = r_active;
    w_rem        = r_rem;
    w_csum       = r_csum;
    w_tx_data    = r_tx_data;
    w_grant_ch   = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_grant) begin
          if (ch0_req && ch1_req) begin
            w_grant_ch = ~r_last_grant;
          end else begin
            w_grant_ch = ch1_req;
          end
          w_active     = w_grant_ch;
          w_last_grant = w_grant_ch;
          w_rem        = w_grant_ch ? ch1_len : ch0_len;
          w_csum       = 8'h00;
          w_tx_data    = HDR_BYTE;
          w_last       = B_HDR;
          w_state      = S_SEND;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SEND: begin
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (uart_tx_done) begin
          case (r_last)
            B_HDR: begin
              w_tx_data = w_id;
              w_csum    = csum_add(r_csum, w_id);
              w_last    = B_ID;
              w_state   = S_SEND;
            end
            B_ID: begin
              w_tx_data = r_rem;
              w_csum    = csum_add(r_csum, r_rem);
              w_last    = B_LEN;
              w_state   = S_SEND;
            end
            B_LEN, B_PAY: begin
              if (r_rem != 8'd0) begin
                w_state = S_FETCH;
              end else begin
                w_tx_data = r_csum;
                w_last    = B_CSUM;
                w_state   = S_SEND;
              end
            end
            B_CSUM: begin
              w_frame_end = 1'b1;
              w_state     = S_IDLE;
            end
            default: begin
              w_state = S_IDLE;
            end
          endcase
        end else begin
          w_state = S_WAIT;
        end
      end
      S_FETCH: begin
        w_state = S_LOAD;
      end
      S_LOAD: begin
        w_tx_data = w_pay;
        w_csum    = csum_add(r_csum, w_pay);
        w_rem     = r_rem - 8'd1;
        w_last    = B_PAY;
        w_state   = S_SEND;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_last       <= B_HDR;
      r_last_grant <= 1'b1;
      r_active     <= 1'b0;
      r_rem        <= 8'h00;
      r_csum       <= 8'h00;
      r_tx_data    <= 8'h00;
      r_tx_en      <= 1'b0;
      r_rd0        <= 1'b0;
      r_rd1        <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last       <= w_last;
      r_last_grant <= w_last_grant;
      r_active     <= w_active;
      r_rem        <= w_rem;
      r_csum       <= w_csum;
      r_tx_data    <= w_tx_data;
      r_tx_en      <= (w_state == S_SEND);
      r_rd0        <= (w_state == S_FETCH) & ~w_active;
      r_rd1        <= (w_state == S_FETCH) & w_active;
      r_done0      <= w_frame_end & ~r_active;
      r_done1      <= w_frame_end & r_active;
      r_busy       <= (w_state != S_IDLE);
    end
  end

  assign uart_tx_data = r_tx_data;
  assign uart_tx_en   = r_tx_en;
  assign ch0_rd       = r_rd0;
  assign ch1_rd       = r_rd1;
  assign ch0_done     = r_done0;
  assign ch1_done     = r_done1;
  assign busy         = r_busy;
  assign active_ch    = r_active;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Randomized scoreboard bench for uart_frame_sched with packet sources and a UART driver model.
module tb_uart_frame_sched;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       req_a [2];
  logic [7:0] len_a [2];
  logic [7:0] dat_a [2];
  logic       ch0_req, ch1_req;
  logic [7:0] ch0_len, ch1_len, ch0_data, ch1_data;
  logic       ch0_rd, ch0_done, ch1_rd, ch1_done;
  logic [7:0] uart_tx_data;
  logic       uart_tx_en, uart_tx_done, busy, active_ch;

  int total = 0;
  int bad = 0;

  assign ch0_req  = req_a[0];
  assign ch1_req  = req_a[1];
  assign ch0_len  = len_a[0];
  assign ch1_len  = len_a[1];
  assign ch0_data = dat_a[0];
  assign ch1_data = dat_a[1];

  uart_frame_sched #(.HDR_BYTE(8'hA5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ch0_req(ch0_req), .ch0_len(ch0_len), .ch0_data(ch0_data), .ch0_rd(ch0_rd), .ch0_done(ch0_done),
    .ch1_req(ch1_req), .ch1_len(ch1_len), .ch1_data(ch1_data), .ch1_rd(ch1_rd), .ch1_done(ch1_done),
    .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en), .uart_tx_done(uart_tx_done),
    .busy(busy), .active_ch(active_ch)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet store: main writes wr_cnt, the source process advances rd_ptr.
  logic [7:0] p_len [2][64];
  logic [7:0] p_dat [2][64][16];
  logic [7:0] pay_buf [16];
  int wr_cnt [2];
  int rd_ptr [2];
  int bidx [2];

  // Scoreboard queues filled from the reference model when a packet is issued.
  logic [7:0] exp_b0 [$];
  logic [7:0] exp_b1 [$];
  int exp_l0 [$];
  int exp_l1 [$];

  task automatic exp_push(input int c, input logic [7:0] b);
    if (c == 0) exp_b0.push_back(b);
    else exp_b1.push_back(b);
  endtask

  task automatic push_expected(input int c, input int k);
    int n;
    int sum;
    logic [7:0] s8;
    n = int'(p_len[c][k]);
    sum = c + n;
    exp_push(c, 8'hA5);
    exp_push(c, (c == 0) ? 8'h00 : 8'h01);
    exp_push(c, p_len[c][k]);
    for (int i = 0; i < n; i++) begin
      exp_push(c, p_dat[c][k][i]);
      sum = sum + int'(p_dat[c][k][i]);
    end
    s8 = 8'(sum % 256);
    exp_push(c, s8);
    if (c == 0) exp_l0.push_back(n);
    else exp_l1.push_back(n);
  endtask

  task automatic add_pkt(input int c, input int n);
    p_len[c][wr_cnt[c]] = 8'(n);
    for (int i = 0; i < 16; i++) p_dat[c][wr_cnt[c]][i] = pay_buf[i];
    push_expected(c, wr_cnt[c]);
    wr_cnt[c] = wr_cnt[c] + 1;
  endtask

  // Packet sources: hold req while a packet is pending, serve one byte per rd strobe.
  initial begin
    for (int c = 0; c < 2; c++) begin
      req_a[c] = 1'b0; len_a[c] = 8'h00; dat_a[c] = 8'h00;
      rd_ptr[c] = 0; bidx[c] = 0; wr_cnt[c] = 0;
    end
    forever begin
      @(posedge sys_clk); #1;
      for (int c = 0; c < 2; c++) begin
        if (sys_rst) begin
          bidx[c] = 0;
        end else begin
          if ((c == 0) ? ch0_done : ch1_done) begin
            rd_ptr[c] = rd_ptr[c] + 1;
            bidx[c] = 0;
          end
          if (((c == 0) ? ch0_rd : ch1_rd) && bidx[c] < 16 && rd_ptr[c] < 64) begin
            dat_a[c] = p_dat[c][rd_ptr[c]][bidx[c]];
            bidx[c] = bidx[c] + 1;
          end
        end
        req_a[c] = (rd_ptr[c] < wr_cnt[c]);
        len_a[c] = req_a[c] ? p_len[c][rd_ptr[c]] : 8'h00;
      end
    end
  end

  // UART driver model: done pulse a configurable number of cycles after each en.
  int drv_lo = 1, drv_hi = 1;
  int stray_req = 0, stray_ack = 0;
  bit drv_out;
  int drv_cnt;
  initial begin
    uart_tx_done = 1'b0; drv_out = 1'b0; drv_cnt = 0;
    forever begin
      @(posedge sys_clk); #1;
      uart_tx_done = 1'b0;
      if (sys_rst) begin
        drv_out = 1'b0;
      end else if (uart_tx_en) begin
        check("en_while_outstanding", 32'(drv_out), 32'd0);
        drv_out = 1'b1;
        drv_cnt = int'($urandom_range(drv_hi, drv_lo));
      end else if (drv_out) begin
        drv_cnt--;
        if (drv_cnt <= 0) begin
          uart_tx_done = 1'b1;
          drv_out = 1'b0;
        end
      end else if (stray_req != stray_ack) begin
        uart_tx_done = 1'b1;
        stray_ack = stray_req;
      end
    end
  end

  // Monitor: compares wire bytes, strobes, spacing and arbitration against the model.
  int cyc = 0, done_cyc = 0, idx = 0, cur_len = 0, cur_ch = 0, rd_cnt = 0, frames_done = 0;
  bit prev_en = 0, prev_busy = 0, prev_r0 = 0, prev_r1 = 0, mdl_last = 1;
  initial begin
    int g;
    int want;
    logic [7:0] e;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (sys_rst) begin
        idx = 0; rd_cnt = 0; prev_en = 0; prev_busy = 0; mdl_last = 1;
      end else begin
        if (busy && !prev_busy) begin
          if (prev_r0 && prev_r1) g = mdl_last ? 0 : 1;
          else g = prev_r1 ? 1 : 0;
          check("grant_channel", 32'(active_ch), 32'(g));
          mdl_last = (g == 1);
        end
        if (uart_tx_en) begin
          check("en_width", 32'(prev_en), 32'd0);
          check("en_while_busy", 32'(busy), 32'd1);
          if (idx == 0) begin
            cur_ch = int'(active_ch);
            if (cur_ch == 0 && exp_l0.size() > 0) cur_len = exp_l0.pop_front();
            else if (cur_ch == 1 && exp_l1.size() > 0) cur_len = exp_l1.pop_front();
            else check("frame_unexpected", 32'd1, 32'd0);
          end else begin
            want = (idx >= 3 && idx < 3 + cur_len) ? 3 : 1;
            check("en_spacing", 32'(cyc - done_cyc), 32'(want));
          end
          if (cur_ch == 0 && exp_b0.size() > 0) begin
            e = exp_b0.pop_front();
            check("wire_byte_ch0", 32'(uart_tx_data), 32'(e));
          end else if (cur_ch == 1 && exp_b1.size() > 0) begin
            e = exp_b1.pop_front();
            check("wire_byte_ch1", 32'(uart_tx_data), 32'(e));
          end else begin
            check("byte_unexpected", 32'(uart_tx_data), 32'h100);
          end
          idx++;
        end
        if (ch0_rd || ch1_rd) begin
          check("rd_channel", {30'd0, ch1_rd, ch0_rd}, (cur_ch == 1) ? 32'd2 : 32'd1);
          check("rd_while_busy", 32'(busy), 32'd1);
          rd_cnt++;
        end
        if (ch0_done || ch1_done) begin
          check("done_channel", {30'd0, ch1_done, ch0_done}, (cur_ch == 1) ? 32'd2 : 32'd1);
          check("done_byte_count", 32'(idx), 32'(cur_len + 4));
          check("done_rd_count", 32'(rd_cnt), 32'(cur_len));
          check("busy_low_at_done", 32'(busy), 32'd0);
          idx = 0; rd_cnt = 0;
          frames_done++;
        end
        if (uart_tx_done) done_cyc = cyc;
        prev_en = uart_tx_en;
        prev_busy = busy;
      end
      prev_r0 = req_a[0];
      prev_r1 = req_a[1];
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check("frames_completed", 32'(frames_done), 32'(target));
  endtask

  task automatic set_pay(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
    for (int i = 0; i < 16; i++) pay_buf[i] = 8'h00;
    pay_buf[0] = b0; pay_buf[1] = b1; pay_buf[2] = b2; pay_buf[3] = b3;
  endtask

  task automatic rand_pay();
    for (int i = 0; i < 16; i++) pay_buf[i] = 8'($urandom_range(255, 0));
  endtask

  initial begin
    int target;
    int n;
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_outputs", {18'd0, uart_tx_data, uart_tx_en, ch0_rd, ch1_rd, ch0_done, ch1_done,
                            busy}, 32'd0);
    check("reset_active_ch", 32'(active_ch), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    set_pay(8'h11, 8'h22, 8'h33, 8'h00);
    add_pkt(0, 3);
    wait_frames(1, 500);

    add_pkt(1, 0);
    wait_frames(2, 500);

    rand_pay(); add_pkt(0, 2);
    rand_pay(); add_pkt(1, 3);
    rand_pay(); add_pkt(0, 1);
    rand_pay(); add_pkt(1, 0);
    wait_frames(6, 2000);

    set_pay(8'hFF, 8'hFF, 8'h00, 8'h00);
    add_pkt(0, 2);
    wait_frames(7, 500);

    drv_lo = 1; drv_hi = 6;
    target = 7;
    for (int k = 0; k < 20; k++) begin
      rand_pay();
      add_pkt(int'($urandom_range(1, 0)), int'($urandom_range(15, 0)));
      target++;
      repeat (int'($urandom_range(40, 0))) @(negedge sys_clk);
    end
    wait_frames(target, 20000);

    drv_lo = 50; drv_hi = 50;
    rand_pay(); add_pkt(0, 3);
    rand_pay(); add_pkt(1, 2);
    target += 2;
    wait_frames(target, 3000);

    drv_lo = 1; drv_hi = 3;
    repeat (3) @(negedge sys_clk);
    stray_req++;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      check("stray_done_idle", {30'd0, busy, uart_tx_en}, 32'd0);
    end
    rand_pay(); add_pkt(1, 2);
    target++;
    wait_frames(target, 500);

    drv_lo = 2; drv_hi = 2;
    rand_pay(); add_pkt(0, 4);
    n = 0;
    while (idx < 5 && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    check("reach_second_payload", 32'(idx), 32'd5);
    @(posedge sys_clk); #2;
    sys_rst = 1'b1;
    #1;
    check("midframe_reset_outputs", {18'd0, uart_tx_data, uart_tx_en, ch0_rd, ch1_rd, ch0_done,
                                     ch1_done, busy}, 32'd0);
    check("midframe_reset_active", 32'(active_ch), 32'd0);
    repeat (2) @(negedge sys_clk);
    exp_b0.delete(); exp_b1.delete(); exp_l0.delete(); exp_l1.delete();
    for (int c = 0; c < 2; c++) begin
      for (int k = rd_ptr[c]; k < wr_cnt[c]; k++) push_expected(c, k);
    end
    rand_pay(); add_pkt(1, 3);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    target += 2;
    wait_frames(target, 1000);

    repeat (5) @(negedge sys_clk);
    check("scoreboard_drained", 32'(exp_b0.size() + exp_b1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_sched.md
# uart_frame_sched

Two-channel frame scheduler that sits in front of the byte-level UART transmit driver. It shares one driver between two packet sources (for example, the beamformer result stream and the status/telemetry source). It arbitrates round-robin, wraps each granted packet into a framed byte sequence (header, channel ID, length, payload, checksum), and sequences the driver one byte at a time using the driver's enable/done handshake.

## Interface

Parameters:
- HDR_BYTE, default 8'hA5: frame start byte.

Ports:
- sys_clk  input  1: system clock; all logic on its rising edge.
- sys_rst  input  1: asynchronous, active-high reset.
- ch0_req  input  1: channel 0 has a packet pending; held high until ch0_done.
- ch0_len  input  8: channel 0 payload length in bytes, 0..255; sampled at grant.
- ch0_data  input  8: channel 0 payload byte; valid the cycle after ch0_rd.
- ch0_rd  output  1: one-cycle pop strobe to the channel 0 source.
- ch0_done  output  1: one-cycle pulse when the channel 0 frame has been fully transmitted.
- ch1_req, ch1_len, ch1_data, ch1_rd, ch1_done: same as channel 0, for channel 1.
- uart_tx_data  output  8: byte presented to the UART driver.
- uart_tx_en  output  1: one-cycle send strobe to the UART driver.
- uart_tx_done  input  1: driver pulse, one cycle, when a byte has finished.
- busy  output  1: high from grant until the done pulse.
- active_ch  output  1: granted channel; valid while busy.

## Operation

- Frame format, on the wire in order: HDR_BYTE, ID (8'h00 or 8'h01), LEN, LEN payload bytes, CSUM.
- CSUM is the 8-bit sum, modulo 256, of ID, LEN and all payload bytes. HDR_BYTE is excluded from the sum.
- States: IDLE, SEND, WAIT, FETCH, LOAD.
- IDLE:
  - If any req is high, grant a channel, latch its length, and clear the checksum accumulator.
  - Then drive HDR_BYTE and go to SEND.
- Arbitration is round-robin using a last_grant register (reset value 1, so ch0 wins the first tie):
  - One request high: that channel is granted.
  - Both high: the channel other than last_grant is granted.
  - last_grant is updated at grant.
- SEND: assert uart_tx_en for exactly one cycle with uart_tx_data stable, then go to WAIT.
- WAIT: hold until uart_tx_done, then select the next step:
  - After HDR: send ID.
  - After ID: send LEN.
  - After LEN, or after a payload byte: if payload bytes remain, go to FETCH; otherwise send CSUM.
  - After CSUM: pulse chX_done, then return to IDLE.
- FETCH: pulse chX_rd for the granted channel only, then go to LOAD.
- LOAD: capture chX_data, add it to the checksum, decrement the remaining count, then go to SEND.
- LEN = 0: no rd strobes are issued; CSUM goes out directly after LEN.
- uart_tx_data is held at its last value between strobes.
- uart_tx_en is never asserted before the done pulse for the previous byte.
- Stray uart_tx_done pulses are ignored outside WAIT.
- Request deassertion mid-frame is ignored: the frame completes. The other channel's req is not sampled until IDLE.

## Timing

- Reset values (asynchronous on sys_rst high):
  - All outputs are 0: uart_tx_data = 8'h00, uart_tx_en, chX_rd, chX_done, busy, active_ch.
  - State = IDLE, last_grant = 1, checksum = 0, remaining count = 0.
- Grant latency: req high in IDLE at edge N gives busy and active_ch at N+1, and uart_tx_en (HDR) at N+1.
- Non-payload bytes (ID, LEN, CSUM): uart_tx_en is asserted 1 cycle after the preceding uart_tx_done cycle.
- Payload bytes:
  - chX_rd is asserted 1 cycle after the preceding done.
  - Data is sampled 1 cycle after rd.
  - uart_tx_en is asserted 1 cycle after sampling, i.e. 3 cycles after the done.
- chX_done is asserted the cycle after CSUM's uart_tx_done. busy falls in that same cycle.
- Earliest next grant is the cycle after chX_done, so the two channels alternate back to back.
- Reset mid-frame: the frame is abandoned with no done pulse. The next frame starts fresh with HDR_BYTE. The UART driver is reset by the same system reset.

## Test plan

- Single ch0 packet, len 3, payload 11 22 33: wire bytes A5 00 03 11 22 33 69; exactly 3 ch0_rd pulses; one ch0_done; ch1_rd never asserted.
- ch1 packet, len 0: wire bytes A5 01 00 01; no ch1_rd; ch1_done after the 4th uart_tx_done.
- Both req high from reset and held through two frames each: frame order ch0, ch1, ch0, ch1; active_ch toggles; each frame is correctly formed.
- Checksum wrap, ch0, len 2, payload FF FF: wire bytes A5 00 02 FF FF 00.
- sys_rst asserted during the second payload byte of a len-4 frame: all outputs are 0 immediately. After release, with both req high, the ch0 frame restarts from A5.
- Handshake check with a slow driver model (done 50 cycles after en): uart_tx_en is always exactly 1 cycle wide, never asserted while a byte is outstanding, and the spacing after done is 1 cycle (non-payload) or 3 cycles (payload).
